// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// It returns {remainder, quotient}. The divider takes DATA_W steps per
// operation and can be annulled while it is running.
module div_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int unsigned RES_W = 2 * DATA_W;

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BYZERO = 2'b01;
    localparam logic [1:0] ON     = 2'b10;
    localparam logic [1:0] END    = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0] quo_q, quo_d;     // dividend bits shifting out, quotient bits shifting in
    logic [DATA_W-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic              neg_q_q, neg_q_d; // quotient must be negated
    logic              neg_r_q, neg_r_d; // remainder must be negated
    logic [RES_W-1:0]  result_d;
    logic              ready_d;

    logic [DATA_W-1:0] mag1, mag2;
    logic [DATA_W+1:0] trial;
    logic [DATA_W-1:0] rem_fix, quo_fix;

    // Next-state, datapath step and registered-output values
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        result_d = result_o;
        ready_d  = ready_o;

        // Operand magnitudes for signed requests
        mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

        // Shift in the next dividend bit, then subtract the divisor as a trial
        trial = {1'b0, rem_q, quo_q[DATA_W-1]} - {2'b00, dvs_q};

        // Final sign fix-up of the unsigned result
        rem_fix = neg_r_q ? -rem_q : rem_q;
        quo_fix = neg_q_q ? -quo_q : quo_q;

        case (state_q)
            FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    cnt_d = '0;
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        rem_d   = '0;
                        quo_d   = mag1;
                        dvs_d   = mag2;
                        neg_q_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r_d = signed_div_i & opdata1_i[DATA_W-1];
                    end
                end
            end

            // The zero-divisor path has a fixed two-edge latency from acceptance
            BYZERO: begin
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d  = END;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end

            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    if (!trial[DATA_W+1]) begin
                        rem_d = trial[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = END;
                    cnt_d    = '0;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end
            end

            END: begin
                if (!start_i) begin
                    state_d  = FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = FREE;
                cnt_d    = '0;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a plain-arithmetic reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          start_edge;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    // Reference: {remainder, quotient} from ordinary integer division
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b", name, act, req);
        end
    endtask

    task automatic check_res(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: compare each new result against the scoreboard head
    logic        ready_prev = 1'b0;
    logic [63:0] held_res   = '0;
    always @(negedge clk) begin
        if (ready_o && !ready_prev) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready: got result %h expected no result", result_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result_o !== e.res) begin
                    failures++;
                    $display("FAIL %s result: got %h expected %h", e.name, result_o, e.res);
                end
                checks++;
                if (edge_cnt - e.start_edge != e.lat) begin
                    failures++;
                    $display("FAIL %s latency: got %0d expected %0d", e.name,
                             edge_cnt - e.start_edge, e.lat);
                end
            end
            held_res = result_o;
        end else if (ready_o && ready_prev) begin
            checks++;
            if (result_o !== held_res) begin
                failures++;
                $display("FAIL hold: got %h expected %h", result_o, held_res);
            end
        end
        ready_prev = ready_o;
    end

    // Drive a request (called just after a rising edge with the DUT in FREE)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input string name);
        exp_t e;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        e.res        = ref_div(a, b, sgn);
        e.start_edge = edge_cnt + 1;
        e.lat        = (b == 32'd0) ? 2 : 33;
        e.name       = name;
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got no ready expected ready within 60 cycles", name);
        end
    endtask

    // Hold start for a few cycles, drop it and confirm outputs clear
    task automatic finish_op(input int hold);
        repeat (hold) @(posedge clk);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        check_bit("drop_ready", ready_o, 1'b0);
        check_res("drop_result", result_o, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input string name, input int hold);
        issue(a, b, sgn, name);
        wait_ready(name);
        finish_op(hold);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset_ready", ready_o, 1'b0);
        check_res("reset_result", result_o, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, "u100_7", 2);
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, "s_m7_2", 0);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, "s_7_m2", 1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, "s_min_m1", 0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, "u_max_1", 0);
        run_op(32'hFFFFFFFF, 32'd1, 1'b1, "s_m1_1", 0);
        run_op(32'd5, 32'd0, 1'b0, "div0", 1);

        // Request with annul in FREE is not accepted
        opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1; annul_i = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            check_bit("annul_free_ready", ready_o, 1'b0);
        end
        start_i = 1'b0; annul_i = 1'b0;
        @(posedge clk); #1;

        // Annul at the 10th ON cycle, then restart at once
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        issue(32'd9, 32'd3, 1'b0, "restart_9_3");
        wait_ready("restart_9_3");
        finish_op(0);

        // Reset while ON with cnt=20
        opdata1_i = 32'd1000; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1 rst = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_bit("rst_on_ready", ready_o, 1'b0);
        check_res("rst_on_result", result_o, 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Reset in END with start held
        issue(32'd20, 32'd6, 1'b0, "rst_end_op");
        wait_ready("rst_end_op");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_bit("rst_end_ready", ready_o, 1'b0);
        check_res("rst_end_result", result_o, 64'd0);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n),
                   int'($urandom_range(0, 3)));
        end

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_empty: got %0d pending expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
